// File: rtl/uart_pkg.sv
// uart_pkg: default sizing constants and width helper shared by the baud generator files
package uart_pkg;
    localparam int DIV_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;
    localparam int OVS_DEF    = 16;

    // Width of an index ranging 0..n-1, never less than one bit
    function automatic int log2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/uart_frac_div.sv
// uart_frac_div: fractional prescaler producing the oversample terminal-count strobe
//   Clock/Reset      : system clock, async active-low reset
//   Enable           : low freezes prescaler and accumulator
//   Divisor/DivFrac  : prescale value, captured into divQ/fracQ on Load
//   Sync             : restarts the prescale period with the (possibly just loaded) divisor
//   Tick             : combinational terminal count, registered by the parent
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [DIV_W-1:0]  Divisor,
    input  logic [FRAC_W-1:0] DivFrac,
    input  logic              Load,
    input  logic              Sync,
    output logic              Tick
);
    logic [DIV_W-1:0]  divQ, count, reloadVal, syncDiv;
    logic [FRAC_W-1:0] fracQ, acc;
    logic [FRAC_W:0]   sum;

    always_comb begin
        sum       = {1'b0, acc} + {1'b0, fracQ};
        reloadVal = divQ - DIV_W'(1) + DIV_W'(sum[FRAC_W]);
        // A coincident Load must already govern the Sync restart
        syncDiv   = Load ? Divisor : divQ;
        Tick      = Enable && (divQ != '0) && (count == '0) && !Sync;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            divQ  <= '0;
            fracQ <= '0;
            count <= '0;
            acc   <= '0;
        end else begin
            if (Load) begin
                divQ  <= Divisor;
                fracQ <= DivFrac;
            end
            if (Sync) begin
                count <= (syncDiv == '0) ? '0 : syncDiv - DIV_W'(1);
                acc   <= '0;
            end else if (Tick) begin
                count <= reloadVal;
                acc   <= sum[FRAC_W-1:0];
            end else if (Enable && divQ != '0) begin
                count <= count - DIV_W'(1);
            end
        end
    end
endmodule

// File: rtl/uart_baud_gen_prog.sv
// uart_baud_gen_prog: programmable fractional baud generator with oversample phase outputs
//   Clock/Reset      : system clock, async active-low reset
//   Enable           : low freezes counters and suppresses ticks
//   Divisor/DivFrac  : prescale value (cycles per oversample tick), captured on Load
//   Sync             : restarts the baud phase for start-bit alignment
//   BaudTick16       : oversample-rate pulse
//   BaudTick         : baud-rate pulse, coincident with OvsPhase wrapping to 0
//   BaudClock        : high while OvsPhase is in the upper half
//   OvsPhase         : oversample index 0..OVS-1
module uart_baud_gen_prog
    import uart_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OVS    = OVS_DEF
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic [DIV_W-1:0]       Divisor,
    input  logic [FRAC_W-1:0]      DivFrac,
    input  logic                   Load,
    input  logic                   Sync,
    output logic                   BaudTick16,
    output logic                   BaudTick,
    output logic                   BaudClock,
    output logic [log2w(OVS)-1:0]  OvsPhase
);
    localparam int PH_W = log2w(OVS);

    logic            tick;
    logic [PH_W-1:0] phaseNext;

    uart_frac_div #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) uDiv (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (Enable),
        .Divisor (Divisor),
        .DivFrac (DivFrac),
        .Load    (Load),
        .Sync    (Sync),
        .Tick    (tick)
    );

    // OVS is a power of two, so the phase wraps by natural overflow
    always_comb phaseNext = Sync ? '0 : OvsPhase + PH_W'(tick);

    // All outputs update on the same edge so BaudClock always agrees with OvsPhase
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            BaudTick16 <= 1'b0;
            BaudTick   <= 1'b0;
            BaudClock  <= 1'b0;
            OvsPhase   <= '0;
        end else begin
            BaudTick16 <= tick;
            BaudTick   <= tick && (OvsPhase == PH_W'(OVS - 1));
            BaudClock  <= phaseNext >= PH_W'(OVS / 2);
            OvsPhase   <= phaseNext;
        end
    end
endmodule

// File: tb/tb_uart_baud_gen_prog.sv
// tb_uart_baud_gen_prog: directed and random checks of the baud generator against a cycle model
module tb_uart_baud_gen_prog;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic              Enable = 1'b0;
    logic              Load = 1'b0;
    logic              Sync = 1'b0;
    logic [DIV_W-1:0]  Divisor = '0;
    logic [FRAC_W-1:0] DivFrac = '0;
    logic              BaudTick16, BaudTick, BaudClock;
    logic [3:0]        OvsPhase;

    int vectors = 0, miscompares = 0, cyc = 0;
    int mDiv, mFrac, mLeft, mAcc, mPhase;
    bit eT16, eTick;
    int ticks[$];
    int bauds[$];
    int hiCnt = 0, prevHi = 0, lastHi = 0;

    always #5 Clock = ~Clock;

    uart_baud_gen_prog #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Enable     (Enable),
        .Divisor    (Divisor),
        .DivFrac    (DivFrac),
        .Load       (Load),
        .Sync       (Sync),
        .BaudTick16 (BaudTick16),
        .BaudTick   (BaudTick),
        .BaudClock  (BaudClock),
        .OvsPhase   (OvsPhase)
    );

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic modelReset();
        mDiv = 0; mFrac = 0; mLeft = 0; mAcc = 0; mPhase = 0; eT16 = 0; eTick = 0;
    endtask

    // mLeft = cycles still to wait before the next oversample tick is due
    task automatic modelStep();
        bit fire;
        int sd;
        fire = Enable && mDiv > 0 && mLeft == 0 && !Sync;
        if (Sync) begin
            sd = Load ? int'(Divisor) : mDiv;
            mLeft = sd > 0 ? sd - 1 : 0;
            mAcc = 0;
            mPhase = 0;
        end else if (fire) begin
            mAcc += mFrac;
            mLeft = mDiv - 1 + mAcc / (1 << FRAC_W);
            mAcc = mAcc % (1 << FRAC_W);
            mPhase = (mPhase + 1) % OVS;
        end else if (Enable && mDiv > 0) begin
            mLeft--;
        end
        eT16 = fire;
        eTick = fire && mPhase == 0;
        if (Load) begin
            mDiv = int'(Divisor);
            mFrac = int'(DivFrac);
        end
    endtask

    task automatic step();
        modelStep();
        @(posedge Clock);
        #1;
        cyc++;
        check("tick16", int'(BaudTick16), int'(eT16));
        check("tick", int'(BaudTick), int'(eTick));
        check("phase", int'(OvsPhase), mPhase);
        check("bclk", int'(BaudClock), int'(mPhase >= OVS / 2));
        if (BaudTick16) ticks.push_back(cyc);
        if (BaudClock) hiCnt++;
        if (BaudTick) begin
            bauds.push_back(cyc);
            lastHi = hiCnt - prevHi;
            prevHi = hiCnt;
        end
        Load = 1'b0;
        Sync = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic waitTick(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!BaudTick16 && n < budget);
        if (!BaudTick16) check("tick_timeout", 0, 1);
    endtask

    task automatic waitBaud(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!BaudTick && n < budget);
        if (!BaudTick) check("baud_timeout", 0, 1);
    endtask

    function automatic int lastGap(input int k);
        if (ticks.size() < k + 1) return -1;
        return ticks[ticks.size() - k] - ticks[ticks.size() - k - 1];
    endfunction

    task automatic checkAllZero(input string tag);
        check(tag, int'({BaudTick16, BaudTick, BaudClock, OvsPhase}), 0);
    endtask

    initial begin
        int n, s, n0;
        modelReset();
        Enable = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        checkAllZero("rst_outputs");
        Reset = 1'b1;
        run(10);
        check("no_tick_before_load", ticks.size(), 0);

        Divisor = 16'd4; DivFrac = 4'd0; Load = 1'b1;
        run(200);
        check("gap4", lastGap(1), 4);
        check("baud64", bauds.size() >= 2 ? bauds[$] - bauds[bauds.size() - 2] : -1, 64);
        check("hi32", lastHi, 32);

        waitTick(10);
        step();
        Divisor = 16'd10; Load = 1'b1;
        waitTick(10);
        check("old_period", lastGap(1), 4);
        waitTick(20);
        check("new_period", lastGap(1), 10);
        waitTick(20);
        check("new_period2", lastGap(1), 10);

        Divisor = 16'd4; Load = 1'b1;
        step();
        n = 0;
        while (OvsPhase != 4'd9 && n < 400) begin
            step();
            n++;
        end
        check("reach_phase9", int'(OvsPhase), 9);
        Sync = 1'b1;
        step();
        s = cyc;
        check("sync_phase", int'(OvsPhase), 0);
        waitTick(20);
        check("sync_tick", cyc - s, 4);
        waitBaud(100);
        check("sync_baud", cyc - s, 64);

        waitTick(10);
        step();
        Enable = 1'b0;
        n0 = ticks.size();
        run(7);
        check("no_tick_disabled", ticks.size() - n0, 0);
        Enable = 1'b1;
        waitTick(30);
        check("stretch7", lastGap(1), 11);

        Divisor = 16'd3; DivFrac = 4'd8; Load = 1'b1; Sync = 1'b1;
        step();
        run(160);
        check("span32", ticks.size() >= 33 ? ticks[$] - ticks[ticks.size() - 33] : -1, 112);
        check("alt34", int'((lastGap(1) == 3 && lastGap(2) == 4) || (lastGap(1) == 4 && lastGap(2) == 3)), 1);

        Divisor = 16'd1; DivFrac = 4'd0; Load = 1'b1; Sync = 1'b1;
        step();
        run(6);
        check("div1_gap", lastGap(1), 1);

        Divisor = 16'd0; Load = 1'b1;
        step();
        n0 = ticks.size();
        run(30);
        check("div0_halt", ticks.size() - n0, 0);

        Divisor = 16'd5; Load = 1'b1;
        run(23);
        #2;
        Reset = 1'b0;
        #1;
        checkAllZero("arst_outputs");
        modelReset();
        repeat (3) @(posedge Clock);
        #1;
        checkAllZero("arst_hold");
        Reset = 1'b1;
        n0 = ticks.size();
        run(20);
        check("post_rst_halt", ticks.size() - n0, 0);
        Divisor = 16'd6; DivFrac = 4'd3; Load = 1'b1;
        waitTick(20);

        repeat (3000) begin
            Enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) begin
                Divisor = 16'($urandom_range(0, 9));
                DivFrac = 4'($urandom);
                Load = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) Sync = 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
